// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial a - b, LSB first, single borrow flop; parallel result
//             with borrow and signed-overflow flags. Updates on falling cp.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         cp,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         ovf,
    output logic         d_ser,
    output logic         d_valid
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  res_q, res_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] count_q, count_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;

    logic w_d;
    logic w_bnext;

    // Full-subtractor cell on the current LSBs
    assign w_d     = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    assign w_bnext = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    sa_d     = a[N-1];
                    sb_d     = b[N-1];
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d    = {w_d, res_q[N-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = w_bnext;
                count_d  = count_q + C_ONE;
                if (count_q == C_LAST) begin
                    // The last bit shifted in is the result's sign bit
                    diff_d  = {w_d, res_q[N-1:1]};
                    bout_d  = w_bnext;
                    ovf_d   = (sa_q ^ sb_q) & (w_d ^ sa_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge cp or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign d_valid    = busy;
    assign d_ser      = busy & w_d;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor against an arithmetic
//             reference model. Samples on rising cp, DUT acts on falling cp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int N = 8;

    logic         cp;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         ovf;
    logic         d_ser;
    logic         d_valid;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.N(N)) dut (
        .cp         (cp),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .d_ser      (d_ser),
        .d_valid    (d_valid)
    );

    initial cp = 1'b1;
    always #5 cp = ~cp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain modular and signed integer arithmetic
    function automatic logic [N-1:0] ref_diff(input logic [N-1:0] x, input logic [N-1:0] y);
        return N'((int'(x) - int'(y)) & ((1 << N) - 1));
    endfunction

    function automatic logic ref_borrow(input logic [N-1:0] x, input logic [N-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
        int sd;
        sd = int'($signed(x)) - int'($signed(y));
        return (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
    endfunction

    // Pulse start for one cycle; on return the accepting falling edge has passed
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        @(posedge cp);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge cp);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
    endtask

    // Check serial bits 0..N-1; optional stray start injected at bit inj
    task automatic check_shift(input logic [N-1:0] exp, input int inj);
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(posedge cp);
            if (i == inj + 1) start = 1'b0;
            chk($sformatf("busy[%0d]", i), {31'd0, busy}, 32'd1);
            chk($sformatf("dser[%0d]", i), {31'd0, d_ser}, {31'd0, exp[i]});
            if (i == inj) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end
        end
    endtask

    task automatic check_done(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        @(posedge cp);
        chk("done",   {31'd0, done},       32'd1);
        chk("busy_d", {31'd0, busy},       32'd0);
        chk("diff",   {24'd0, diff},       {24'd0, ref_diff(ta, tb_v)});
        chk("borrow", {31'd0, borrow_out}, {31'd0, ref_borrow(ta, tb_v)});
        chk("ovf",    {31'd0, ovf},        {31'd0, ref_ovf(ta, tb_v)});
    endtask

    task automatic full_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        launch(ta, tb_v);
        check_shift(ref_diff(ta, tb_v), -10);
        check_done(ta, tb_v);
        @(posedge cp);
        chk("done_1cyc", {31'd0, done}, 32'd0);
    endtask

    int done_cnt;
    int last_done;
    int gap_ok;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge cp);
        chk("rst_busy", {31'd0, busy},  32'd0);
        chk("rst_done", {31'd0, done},  32'd0);
        chk("rst_diff", {24'd0, diff},  32'd0);
        chk("rst_dval", {31'd0, d_valid}, 32'd0);
        rst = 1'b0;
        @(posedge cp);

        // Directed cases
        full_op(8'h5A, 8'h23);
        full_op(8'h10, 8'h20);
        full_op(8'h80, 8'h01);
        full_op(8'h00, 8'h00);
        full_op(8'h7F, 8'hFF);

        // Stray start mid-shift and in the DONE cycle are both ignored
        launch(8'h5A, 8'h23);
        check_shift(8'h37, 3);
        check_done(8'h5A, 8'h23);
        chk("inj_diff", {24'd0, diff}, 32'h37);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(posedge cp);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("done_ign_busy%0d", i), {31'd0, busy}, 32'd0);
            @(posedge cp);
        end

        // Asynchronous reset during bit 4
        launch(8'h5A, 8'h23);
        repeat (4) @(posedge cp);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy},       32'd0);
        chk("arst_done", {31'd0, done},       32'd0);
        chk("arst_diff", {24'd0, diff},       32'd0);
        chk("arst_bor",  {31'd0, borrow_out}, 32'd0);
        chk("arst_ovf",  {31'd0, ovf},        32'd0);
        chk("arst_dser", {31'd0, d_ser},      32'd0);
        chk("arst_dval", {31'd0, d_valid},    32'd0);
        @(posedge cp);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge cp);
            chk($sformatf("arst_nodone%0d", i), {31'd0, done}, 32'd0);
        end
        full_op(8'h03, 8'h05);

        // Randomised operations
        for (int k = 0; k < 20; k++) begin
            full_op(N'($urandom), N'($urandom));
        end

        // start held high: repeated operations, each with the same result
        done_cnt  = 0;
        last_done = -1;
        gap_ok    = 1;
        @(posedge cp);
        start = 1'b1;
        a     = 8'h09;
        b     = 8'h04;
        for (int c = 0; c < 6 * (N + 2); c++) begin
            @(posedge cp);
            if (done) begin
                chk("b2b_diff", {24'd0, diff}, 32'h05);
                if (last_done >= 0 && (c - last_done) != N + 1 && (c - last_done) != N + 2)
                    gap_ok = 0;
                last_done = c;
                done_cnt++;
            end
        end
        start = 1'b0;
        chk("b2b_count_ge5", {31'd0, done_cnt >= 5}, 32'd1);
        chk("b2b_gap",       gap_ok, 32'd1);
        repeat (N + 3) @(posedge cp);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
